// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared constants and types for the n-lane decode stage
package decode_pkg;

    localparam logic [3:0] REG_PC = 4'd15;

    localparam int LANES_DEF = 3;
    localparam int DW_DEF    = 18;

    typedef enum logic [1:0] {
        IMM_B8  = 2'b00,
        IMM_B12 = 2'b01,
        IMM_BR  = 2'b10,
        IMM_W24 = 2'b11
    } imm_src_t;

    typedef logic [LANES_DEF-1:0][DW_DEF-1:0] lane_vec_t;

endpackage

// File: rtl/regfile_nlane.sv
// rtl/regfile_nlane.sv - multi-lane register file, R15 reads PC, optional DECODE_WRITE_BYPASS_EN forwarding
module regfile_nlane
    import decode_pkg::*;
#(
    parameter int NLANES = 3,
    parameter int DW     = 18,
    parameter int NREGS  = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [AW-1:0]        wa,
    input  logic [NLANES*DW-1:0] wd,
    input  logic [AW-1:0]        ra1,
    input  logic [AW-1:0]        ra2,
    input  logic [NLANES*DW-1:0] r15,
    output logic [NLANES*DW-1:0] rd1,
    output logic [NLANES*DW-1:0] rd2
);

    localparam logic [AW-1:0] PC_A = AW'(REG_PC);

    logic [NLANES*DW-1:0] mem [NREGS];

    // Entry 15 is never written; its reads are served from r15 instead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != PC_A)) begin
            mem[wa] <= wd;
        end
    end

    always_comb begin
        if (ra1 == PC_A) begin
            rd1 = r15;
        end
`ifdef DECODE_WRITE_BYPASS_EN
        else if (we && (wa == ra1)) begin
            rd1 = wd;
        end
`endif
        else begin
            rd1 = mem[ra1];
        end
    end

    always_comb begin
        if (ra2 == PC_A) begin
            rd2 = r15;
        end
`ifdef DECODE_WRITE_BYPASS_EN
        else if (we && (wa == ra2)) begin
            rd2 = wd;
        end
`endif
        else begin
            rd2 = mem[ra2];
        end
    end

endmodule

// File: rtl/decode_stage_nlane.sv
// rtl/decode_stage_nlane.sv - decode stage with n-lane regfile and D/E register (DECODE_WRITE_BYPASS_EN optional)
module decode_stage_nlane
    import decode_pkg::*;
#(
    parameter int NLANES = 3,
    parameter int DW     = 18,
    parameter int NREGS  = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr_d,
    input  logic                 valid_d,
    input  logic                 stall_d,
    input  logic                 flush_d,
    input  logic [1:0]           reg_src_d,
    input  logic [1:0]           imm_src_d,
    input  logic                 reg_write_w,
    input  logic [AW-1:0]        wa3_w,
    input  logic [NLANES*DW-1:0] wd3_w,
    input  logic [NLANES*DW-1:0] r15_d,
    output logic [NLANES*DW-1:0] rd1_e,
    output logic [NLANES*DW-1:0] rd2_e,
    output logic [DW-1:0]        ext_imm_e,
    output logic [AW-1:0]        ra1_e,
    output logic [AW-1:0]        ra2_e,
    output logic [AW-1:0]        wa3_e,
    output logic                 valid_e
);

    logic [AW-1:0]        ra1_d, ra2_d, wa3_d;
    logic [NLANES*DW-1:0] rd1_d, rd2_d;
    logic [DW-1:0]        ext_imm_d;
    logic                 unused_instr_hi;

    assign unused_instr_hi = ^instr_d[31:24];

    assign ra1_d = reg_src_d[0] ? AW'(REG_PC) : AW'(instr_d[19:16]);
    assign ra2_d = reg_src_d[1] ? AW'(instr_d[15:12]) : AW'(instr_d[3:0]);
    assign wa3_d = AW'(instr_d[15:12]);

    regfile_nlane #(
        .NLANES (NLANES),
        .DW     (DW),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .we  (reg_write_w),
        .wa  (wa3_w),
        .wd  (wd3_w),
        .ra1 (ra1_d),
        .ra2 (ra2_d),
        .r15 (r15_d),
        .rd1 (rd1_d),
        .rd2 (rd2_d)
    );

    // Branch offsets are word-scaled and signed; other modes are unsigned fields.
    always_comb begin
        ext_imm_d = '0;
        case (imm_src_t'(imm_src_d))
            IMM_B8:  ext_imm_d = DW'({56'b0, instr_d[7:0]});
            IMM_B12: ext_imm_d = DW'({52'b0, instr_d[11:0]});
            IMM_BR:  ext_imm_d = DW'({{38{instr_d[23]}}, instr_d[23:0], 2'b00});
            IMM_W24: ext_imm_d = DW'({40'b0, instr_d[23:0]});
            default: ext_imm_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1_e     <= '0;
            rd2_e     <= '0;
            ext_imm_e <= '0;
            ra1_e     <= '0;
            ra2_e     <= '0;
            wa3_e     <= '0;
            valid_e   <= 1'b0;
        end else if (flush_d) begin
            rd1_e     <= '0;
            rd2_e     <= '0;
            ext_imm_e <= '0;
            ra1_e     <= '0;
            ra2_e     <= '0;
            wa3_e     <= '0;
            valid_e   <= 1'b0;
        end else if (!stall_d) begin
            rd1_e     <= rd1_d;
            rd2_e     <= rd2_d;
            ext_imm_e <= ext_imm_d;
            ra1_e     <= ra1_d;
            ra2_e     <= ra2_d;
            wa3_e     <= wa3_d;
            valid_e   <= valid_d;
        end
    end

endmodule

// File: tb/tb_decode_stage_nlane.sv
// tb/tb_decode_stage_nlane.sv - randomized self-checking bench for decode_stage_nlane
module tb_decode_stage_nlane;
    import decode_pkg::*;

    localparam int NL = 3;
    localparam int DW = 18;
    localparam int W  = NL * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   instr_d;
    logic          valid_d, stall_d, flush_d;
    logic [1:0]    reg_src_d, imm_src_d;
    logic          reg_write_w;
    logic [3:0]    wa3_w;
    logic [W-1:0]  wd3_w, r15_d;
    logic [W-1:0]  rd1_e, rd2_e;
    logic [DW-1:0] ext_imm_e;
    logic [3:0]    ra1_e, ra2_e, wa3_e;
    logic          valid_e;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  regs [16];
    logic [W-1:0]  exp_rd1, exp_rd2;
    logic [DW-1:0] exp_imm;
    logic [3:0]    exp_ra1, exp_ra2, exp_wa3;
    logic          exp_v;
    logic [W-1:0]  held;
    lane_vec_t     lv;

    always #5 clk = ~clk;

    decode_stage_nlane dut (
        .clk         (clk),
        .rst         (rst),
        .instr_d     (instr_d),
        .valid_d     (valid_d),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .reg_src_d   (reg_src_d),
        .imm_src_d   (imm_src_d),
        .reg_write_w (reg_write_w),
        .wa3_w       (wa3_w),
        .wd3_w       (wd3_w),
        .r15_d       (r15_d),
        .rd1_e       (rd1_e),
        .rd2_e       (rd2_e),
        .ext_imm_e   (ext_imm_e),
        .ra1_e       (ra1_e),
        .ra2_e       (ra2_e),
        .wa3_e       (wa3_e),
        .valid_e     (valid_e)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mread(input logic [3:0] a);
        if (a == 4'd15) return r15_d;
`ifdef DECODE_WRITE_BYPASS_EN
        if (reg_write_w && wa3_w == a) return wd3_w;
`endif
        return regs[a];
    endfunction

    function automatic logic [DW-1:0] mimm(input logic [31:0] ins, input logic [1:0] m);
        longint v;
        case (m)
            2'd0: v = longint'(ins & 32'hFF);
            2'd1: v = longint'(ins & 32'hFFF);
            2'd2: begin
                v = longint'(ins & 32'hFFFFFF);
                if (ins[23]) v = v - 64'h1000000;
                v = v * 4;
            end
            default: v = longint'(ins & 32'hFFFFFF);
        endcase
        return v[DW-1:0];
    endfunction

    task automatic model_zero();
        exp_rd1 = '0; exp_rd2 = '0; exp_imm = '0;
        exp_ra1 = '0; exp_ra2 = '0; exp_wa3 = '0; exp_v = 1'b0;
    endtask

    task automatic check_e();
        check("rd1_e", 64'(rd1_e), 64'(exp_rd1));
        check("rd2_e", 64'(rd2_e), 64'(exp_rd2));
        check("ext_imm_e", 64'(ext_imm_e), 64'(exp_imm));
        check("ra1_e", 64'(ra1_e), 64'(exp_ra1));
        check("ra2_e", 64'(ra2_e), 64'(exp_ra2));
        check("wa3_e", 64'(wa3_e), 64'(exp_wa3));
        check("valid_e", 64'(valid_e), 64'(exp_v));
    endtask

    task automatic step();
        logic [3:0] a1, a2;
        a1 = reg_src_d[0] ? 4'd15 : instr_d[19:16];
        a2 = reg_src_d[1] ? instr_d[15:12] : instr_d[3:0];
        if (flush_d) begin
            model_zero();
        end else if (!stall_d) begin
            exp_rd1 = mread(a1);
            exp_rd2 = mread(a2);
            exp_imm = mimm(instr_d, imm_src_d);
            exp_ra1 = a1;
            exp_ra2 = a2;
            exp_wa3 = instr_d[15:12];
            exp_v   = valid_d;
        end
        if (reg_write_w && wa3_w != 4'd15) regs[wa3_w] = wd3_w;
        @(posedge clk);
        #1;
        check_e();
    endtask

    task automatic idle();
        instr_d = '0; valid_d = 0; stall_d = 0; flush_d = 0;
        reg_src_d = '0; imm_src_d = '0; reg_write_w = 0; wa3_w = '0;
        wd3_w = '0; r15_d = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        instr_d = 32'hFFFFFFFF;
        valid_d = 1'b1;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        model_zero();
        repeat (2) @(posedge clk);
        #1;
        check_e();
        rst = 1'b0;

        // every register reads zero after reset
        idle();
        for (int r = 0; r < 15; r++) begin
            instr_d = {12'h0, 4'(r), 12'h0, 4'(r)};
            valid_d = 1'b1;
            step();
            check("post_reset_rd1", 64'(rd1_e), 64'h0);
        end

        // write r3 then read it
        idle();
        reg_write_w = 1; wa3_w = 4'd3; wd3_w = {18'h1, 18'h2, 18'h3};
        step();
        idle();
        instr_d[19:16] = 4'd3; valid_d = 1;
        step();
        check("wr_rd_rd1", 64'(rd1_e), 64'({18'h1, 18'h2, 18'h3}));
        check("wr_rd_valid", 64'(valid_e), 64'h1);

        // R15 override and ignored write to 15
        idle();
        lv = '{default: 18'h3FFFF};
        reg_write_w = 1; wa3_w = 4'd15; wd3_w = lv;
        r15_d = {18'h8, 18'h8, 18'h8}; reg_src_d = 2'b01;
        step();
        check("r15_rd1", 64'(rd1_e), 64'({18'h8, 18'h8, 18'h8}));

        // immediate modes
        idle();
        imm_src_d = 2'b10; instr_d = 32'h00FFFFFF;
        step();
        check("imm_br", 64'(ext_imm_e), 64'h3FFFC);
        imm_src_d = 2'b01; instr_d = 32'h00000ABC;
        step();
        check("imm_b12", 64'(ext_imm_e), 64'h00ABC);

        // stall holds, flush beats stall
        idle();
        instr_d = 32'h3; valid_d = 1;
        step();
        held = {18'h1, 18'h2, 18'h3};
        for (int i = 0; i < 3; i++) begin
            stall_d = 1; instr_d = $urandom; valid_d = 1'($urandom);
            r15_d = W'({$urandom, $urandom});
            step();
            check("stall_hold_rd2", 64'(rd2_e), 64'(held));
        end
        stall_d = 1; flush_d = 1;
        step();
        check("flush_valid", 64'(valid_e), 64'h0);
        check("flush_rd2", 64'(rd2_e), 64'h0);

        // same-cycle write and read of r5
        idle();
        lv = '{default: 18'h155};
        reg_write_w = 1; wa3_w = 4'd5; wd3_w = lv;
        instr_d[19:16] = 4'd5; valid_d = 1;
        step();
`ifdef DECODE_WRITE_BYPASS_EN
        check("bypass_rd1", 64'(rd1_e), 64'({18'h155, 18'h155, 18'h155}));
`else
        check("bypass_rd1", 64'(rd1_e), 64'h0);
`endif

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            instr_d     = $urandom;
            valid_d     = 1'($urandom);
            stall_d     = ($urandom_range(0, 3) == 0);
            flush_d     = ($urandom_range(0, 7) == 0);
            reg_src_d   = 2'($urandom);
            imm_src_d   = 2'($urandom);
            reg_write_w = 1'($urandom);
            wa3_w       = ($urandom_range(0, 2) == 0) ? instr_d[19:16] : 4'($urandom);
            wd3_w       = W'({$urandom, $urandom});
            r15_d       = W'({$urandom, $urandom});
            step();
        end

        // asynchronous reset while stalled
        idle();
        stall_d = 1;
        step();
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) regs[i] = '0;
        model_zero();
        check_e();
        #2;
        rst = 1'b0;
        idle();
        for (int r = 0; r < 15; r++) begin
            instr_d = {12'h0, 4'(r), 12'h0, 4'(14 - r)};
            valid_d = 1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
